// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED blink scheduler: FSM state encoding and
// small width helpers for the parameterised counters.
package led_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ON   = 3'd1,
        ST_OFF  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } led_state_e;

    localparam int STATE_W = 3;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_blink_scheduler_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV cycles, counted
// from the most recent restart.
module tick_prescaler
    import led_sched_pkg::*;
#(
    parameter int DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = width_for(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of the single status LED: grants one requester at a time,
// plays its blink burst with tick-exact timing, then a dark gap and a done pulse.
module led_blink_scheduler
    import led_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 4,
    parameter int TICK_DIV  = 250000,
    parameter int ON_TICKS  = 20,
    parameter int OFF_TICKS = 20,
    parameter int GAP_TICKS = 100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*CNT_W-1:0]     req_count,
    output logic [N_REQ-1:0]           req_ack,
    output logic [N_REQ-1:0]           req_done,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       led,
    output logic [STATE_W-1:0]         dbg_state
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int PH_W = width_for(max3(ON_TICKS, OFF_TICKS, GAP_TICKS));

    // Handshake: a requester holds req_valid (and its count) until it sees
    // req_ack for its index, then drops valid the following cycle. Valid is
    // only looked at while idle; req_done later marks the end of that burst.

    led_state_e        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              led_q, led_d;

    logic              found;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    logic [CNT_W-1:0]  gnt_count;
    logic [PH_W-1:0]   ph_last;
    logic              phase_end;
    logic              restart;
    logic              tick;
    logic [N_REQ-1:0]  ack_c;
    logic [N_REQ-1:0]  done_c;

    tick_prescaler #(
        .DIV(TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_count = req_count[int'(gnt_idx)*CNT_W +: CNT_W];

    always_comb begin
        ph_last = '0;
        case (state_q)
            ST_ON:   ph_last = PH_W'(ON_TICKS - 1);
            ST_OFF:  ph_last = PH_W'(OFF_TICKS - 1);
            ST_GAP:  ph_last = PH_W'(GAP_TICKS - 1);
            default: ph_last = '0;
        endcase
    end

    assign phase_end = tick && (phase_q == ph_last);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        ack_c   = '0;
        done_c  = '0;
        restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    ack_c[gnt_idx] = 1'b1;
                    rem_d          = gnt_count;
                    gid_d          = gnt_idx;
                    ptr_d          = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                    restart        = 1'b1;
                    phase_d        = '0;
                    state_d        = (gnt_count == '0) ? ST_DONE : ST_ON;
                end
            end
            ST_ON: begin
                if (phase_end) begin
                    phase_d = '0;
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q > CNT_W'(1)) ? ST_OFF : ST_GAP;
                end else if (tick) begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_OFF: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = ST_ON;
                end else if (tick) begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = ST_DONE;
                end else if (tick) begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_DONE: begin
                done_c[gid_q] = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        led_d = (state_d == ST_ON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            rem_q   <= '0;
            phase_q <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    // Reset aborts everything at once, including a pulse due this cycle.
    assign req_ack   = rst ? '0 : ack_c;
    assign req_done  = rst ? '0 : done_c;
    assign grant_id  = gid_q;
    assign busy      = (state_q != ST_IDLE);
    assign led       = led_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Randomised bench for led_blink_scheduler: a timeline model predicts acks,
// dones and per-cycle LED/busy levels from the burst arithmetic.
module tb_led_blink_scheduler;

  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int DIV = 4;
  localparam int ON  = 2;
  localparam int OFF = 3;
  localparam int GAP = 5;
  localparam int EW  = 33;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid;
  logic [N*CW-1:0] req_count;
  logic [N-1:0] req_ack;
  logic [N-1:0] req_done;
  logic [1:0] grant_id;
  logic busy;
  logic led;
  logic [2:0] dbg_state;

  led_blink_scheduler #(
    .N_REQ(N), .CNT_W(CW), .TICK_DIV(DIV),
    .ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_count(req_count),
    .req_ack(req_ack), .req_done(req_done), .grant_id(grant_id),
    .busy(busy), .led(led), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int auto_mode = 0;

  // scoreboard: {kind(1)=0 ack/1 done, cycle(24), vector(8)}
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d got=timeout exp=completion", name, cyc);
  endtask

  function automatic logic [EW-1:0] mk_ev(input bit kind, input int c, input logic [N-1:0] v);
    logic [EW-1:0] e;
    e = '0;
    e[32] = kind;
    e[31:8] = c[23:0];
    e[N-1:0] = v;
    return e;
  endfunction

  // LED level t cycles after the grant cycle's successor, for a count of k.
  function automatic bit led_at(input int t, input int k);
    int p;
    p = t / DIV;
    if (k == 0) return 1'b0;
    return (p < k*ON + (k-1)*OFF) && ((p % (ON + OFF)) < ON);
  endfunction

  // reference model
  bit m_active = 1'b0;
  int m_g = 0, m_gc = 0, m_dc = 0, m_k = 0, m_ptr = 0, m_ack_cnt = 0;
  logic [N-1:0] m_ack_vec = '0;
  bit exp_busy, exp_led;
  int exp_gid;

  always @(negedge clk) begin
    exp_busy = m_active && (cyc > m_gc);
    exp_led  = exp_busy && led_at(cyc - m_gc - 1, m_k);
    exp_gid  = m_g;
    m_ack_vec = '0;
    if (rst) begin
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (int'(exp_q[i][31:8]) >= cyc) exp_q.delete(i);
      m_active = 1'b0;
      m_ptr = 0;
    end else if (m_active) begin
      if (cyc == m_dc) m_active = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (!m_active && req_valid[j]) begin
          m_active = 1'b1;
          m_g = j;
          m_k = int'(req_count[j*CW +: CW]);
          m_gc = cyc;
          m_dc = (m_k == 0) ? cyc + 1 : cyc + 1 + (m_k*ON + (m_k-1)*OFF + GAP)*DIV;
          m_ptr = (j + 1) % N;
          m_ack_vec[j] = 1'b1;
          m_ack_cnt++;
          exp_q.push_back(mk_ev(1'b0, cyc, N'(1) << j));
          exp_q.push_back(mk_ev(1'b1, m_dc, N'(1) << j));
        end
      end
    end
  end

  // monitor
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      logic [EW-1:0] obs, front;
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("led", 64'(led), 64'(exp_led));
      if (exp_busy) chk("grant_id", 64'(grant_id), 64'(exp_gid));
      while (exp_q.size() > 0 && int'(exp_q[0][31:8]) < cyc) begin
        front = exp_q.pop_front();
        chk("missing_event", 64'(0), 64'(front));
      end
      if (req_ack != '0 && req_done != '0) chk("ack_done_overlap", 64'(req_done), 64'(0));
      if (req_ack != '0 || req_done != '0) begin
        obs = (req_ack != '0) ? mk_ev(1'b0, cyc, req_ack) : mk_ev(1'b1, cyc, req_done);
        if (exp_q.size() == 0) chk("unexpected_event", 64'(obs), 64'(0));
        else begin
          front = exp_q.pop_front();
          chk("event", 64'(obs), 64'(front));
        end
      end
    end
  end

  // driver
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_mode == 2) rst = ($urandom_range(0, 499) == 0);
    for (int i = 0; i < N; i++) begin
      if (m_ack_vec[i]) req_valid[i] = 1'b0;
      else if (auto_mode != 0 && !req_valid[i] &&
               (auto_mode == 1 || $urandom_range(0, 7) == 0)) begin
        req_valid[i] = 1'b1;
        req_count[i*CW +: CW] = (auto_mode == 1) ? CW'(1) : CW'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      if (!m_active && req_valid == '0) return;
      step();
    end
    timeout_fail(name);
  endtask

  initial begin
    int target, g0;
    bit hit;
    rst = 1'b1;
    req_valid = '0;
    req_count = '0;
    step();
    mon_en = 1'b1;
    step();
    step();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_led", 64'(led), 64'(0));
    chk("reset_grant_id", 64'(grant_id), 64'(0));
    chk("reset_state", 64'(dbg_state), 64'(0));
    chk("reset_ack", 64'(req_ack), 64'(0));
    rst = 1'b0;
    step();

    // single request, count 2
    req_valid = 4'b0001;
    req_count[0 +: CW] = 4'd2;
    wait_idle(200, "single_timeout");

    // pointer wrap: serve 3 alone, then 0 and 3 together
    req_valid = 4'b1000;
    req_count[3*CW +: CW] = 4'd1;
    wait_idle(200, "wrap_a_timeout");
    req_valid = 4'b1001;
    req_count[0 +: CW] = 4'd1;
    wait_idle(300, "wrap_b_timeout");

    // fairness: all requesters keep asking with count 1
    target = m_ack_cnt + 5;
    auto_mode = 1;
    hit = 1'b0;
    for (int n = 0; n < 600 && !hit; n++) begin
      if (m_ack_cnt >= target) hit = 1'b1;
      else step();
    end
    if (!hit) timeout_fail("fair_timeout");
    auto_mode = 0;
    wait_idle(600, "fair_drain_timeout");

    // count zero
    req_valid = 4'b0100;
    req_count[2*CW +: CW] = 4'd0;
    wait_idle(50, "zero_timeout");

    // late valid during another burst
    req_valid = 4'b0100;
    req_count[2*CW +: CW] = 4'd1;
    repeat (10) step();
    req_valid[1] = 1'b1;
    req_count[1*CW +: CW] = 4'd2;
    wait_idle(300, "late_timeout");

    // reset in the second ON phase
    req_valid = 4'b0010;
    req_count[1*CW +: CW] = 4'd3;
    step();
    g0 = m_gc;
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      if (cyc >= g0 + 24) hit = 1'b1;
      else step();
    end
    if (!hit) timeout_fail("reset_wait_timeout");
    rst = 1'b1;
    req_valid = 4'b1001;
    req_count[0 +: CW] = 4'd1;
    req_count[3*CW +: CW] = 4'd1;
    step();
    rst = 1'b0;
    chk("post_reset_led", 64'(led), 64'(0));
    chk("post_reset_busy", 64'(busy), 64'(0));
    wait_idle(300, "post_reset_timeout");

    // random traffic with occasional resets
    auto_mode = 2;
    repeat (2500) step();
    auto_mode = 0;
    rst = 1'b0;
    wait_idle(1500, "random_drain_timeout");
    repeat (3) step();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
